// File: rtl/mem_port_arbiter.sv
// Arbiter sharing a single-port unified memory between instruction fetch and the data port.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive denied cycles.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = `ADDR_WIDTH,
   parameter int DATA_WIDTH   = `DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0]            starve_cnt_r;
   logic                  force_if_s;
   logic                  d_gnt_s;
   logic                  if_gnt_s;
   logic                  if_rvalid_r;
   logic                  d_rvalid_r;
   logic [DATA_WIDTH-1:0] if_rdata_r;
   logic [DATA_WIDTH-1:0] d_rdata_r;

   // Grant decision and memory port steering; grants are suppressed while reset is held
   always_comb begin
      force_if_s = if_req && (starve_cnt_r == LIMIT);
      d_gnt_s    = 1'b0;
      if_gnt_s   = 1'b0;
      mem_addr   = {ADDR_WIDTH{1'b0}};
      mem_we     = 1'b0;
      if (rst_n) begin
         d_gnt_s  = d_req && !force_if_s;
         if_gnt_s = if_req && !d_gnt_s;
      end else begin
         d_gnt_s  = 1'b0;
         if_gnt_s = 1'b0;
      end
      if (d_gnt_s) begin
         mem_addr = d_addr;
         mem_we   = d_we;
      end else if (if_gnt_s) begin
         mem_addr = if_addr;
         mem_we   = 1'b0;
      end else begin
         mem_addr = {ADDR_WIDTH{1'b0}};
         mem_we   = 1'b0;
      end
   end

   // Count consecutive denied fetch cycles, saturating at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_r <= 4'd0;
      end else if (if_gnt_s || !if_req) begin
         starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != LIMIT) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   // Capture read data one cycle after the granted read; rdata holds between reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid_r <= 1'b0;
         d_rvalid_r  <= 1'b0;
         if_rdata_r  <= {DATA_WIDTH{1'b0}};
         d_rdata_r   <= {DATA_WIDTH{1'b0}};
      end else begin
         if_rvalid_r <= if_gnt_s;
         d_rvalid_r  <= d_gnt_s && !d_we;
         if (if_gnt_s) begin
            if_rdata_r <= mem_rdata;
         end else begin
            if_rdata_r <= if_rdata_r;
         end
         if (d_gnt_s && !d_we) begin
            d_rdata_r <= mem_rdata;
         end else begin
            d_rdata_r <= d_rdata_r;
         end
      end
   end

   assign if_gnt    = if_gnt_s;
   assign d_gnt     = d_gnt_s;
   assign if_rvalid = if_rvalid_r;
   assign d_rvalid  = d_rvalid_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;
   assign mem_wdata = d_wdata;

endmodule
